// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch requester
// and the load/store requester. One access is outstanding at a time. The
// read response returns MEM_LAT cycles after issue and is routed to the
// requester that owns the access. Data requests win over fetch.
//
// Optional feature: define ARB_STARVE_GUARD_EN to build the fetch
// starvation guard. After STARVE_MAX data grants made while fetch waits,
// the next issue goes to fetch. Without the macro, data priority is
// strict and no counter is built.
//
// Grants and the mem_* issue signals are combinational from the request
// inputs, so an issue lands in the same cycle as the request.

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    // fetch requester
    input  logic                  if_req_i,
    input  logic [ADDR_W-1:0]     if_addr_i,
    output logic                  if_gnt_o,
    output logic                  if_rvalid_o,
    output logic [DATA_W-1:0]     if_rdata_o,
    // load/store requester
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [ADDR_W-1:0]     d_addr_i,
    input  logic [DATA_W-1:0]     d_wdata_i,
    input  logic [DATA_W/8-1:0]   d_wmask_i,
    output logic                  d_gnt_o,
    output logic                  d_rvalid_o,
    output logic [DATA_W-1:0]     d_rdata_o,
    // memory port
    output logic                  mem_en_o,
    output logic                  mem_we_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [DATA_W-1:0]     mem_wdata_o,
    output logic [DATA_W/8-1:0]   mem_wmask_o,
    input  logic [DATA_W-1:0]     mem_rdata_i
);

    localparam int MASK_W   = DATA_W / 8;
    // WAIT lasts MEM_LAT-1 cycles; the counter expires at zero.
    localparam int CNT_LOAD = (MEM_LAT > 2) ? (MEM_LAT - 2) : 0;
    localparam int CNT_W    = (CNT_LOAD > 1) ? $clog2(CNT_LOAD + 1) : 1;

    // Illegal configurations stop elaboration.
    if (MEM_LAT < 1 || STARVE_MAX < 1) begin : g_param_check
        $error("mem_port_arbiter: MEM_LAT and STARVE_MAX must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               owner_data_q;   // 1: data requester owns the access
    logic               owner_data_d;
    logic               we_q;           // outstanding access is a store
    logic               we_d;

    logic               can_issue_s;
    logic               force_fetch_s;
    logic               grant_d_s;
    logic               grant_if_s;
    logic               issue_s;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    logic [STARVE_W-1:0] starve_q;
    logic [STARVE_W-1:0] starve_d;
`endif

    // State register: FSM state, wait counter, owner and store flag.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            owner_data_q <= 1'b0;
            we_q         <= 1'b0;
`ifdef ARB_STARVE_GUARD_EN
            starve_q     <= {STARVE_W{1'b0}};
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_data_q <= owner_data_d;
            we_q         <= we_d;
`ifdef ARB_STARVE_GUARD_EN
            starve_q     <= starve_d;
`endif
        end
    end

    // Next-state logic: arbitration, FSM transitions and wait countdown.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_data_d  = owner_data_q;
        we_d          = we_q;
        force_fetch_s = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
        starve_d      = starve_q;
        force_fetch_s = (starve_q == STARVE_W'(STARVE_MAX)) && if_req_i;
`endif

        // The RESP cycle may carry the next issue; WAIT never does.
        can_issue_s = rst_ni && ((state_q == ST_IDLE) || (state_q == ST_RESP));
        grant_d_s   = can_issue_s && d_req_i && !force_fetch_s;
        grant_if_s  = can_issue_s && if_req_i && !grant_d_s;
        issue_s     = grant_d_s || grant_if_s;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_WAIT: begin
                if (cnt_q == {CNT_W{1'b0}}) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (issue_s) begin
            state_d      = (MEM_LAT > 1) ? ST_WAIT : ST_RESP;
            cnt_d        = CNT_W'(CNT_LOAD);
            owner_data_d = grant_d_s;
            we_d         = grant_d_s && d_we_i;
`ifdef ARB_STARVE_GUARD_EN
            if (grant_if_s) begin
                starve_d = {STARVE_W{1'b0}};
            end else if (if_req_i) begin
                starve_d = starve_q + STARVE_W'(1);
            end else begin
                starve_d = starve_q;
            end
`endif
        end else begin
            owner_data_d = owner_data_q;
        end
    end

    // Output logic: issue strobes to memory and response routing in RESP.
    always_comb begin
        if_gnt_o    = 1'b0;
        d_gnt_o     = 1'b0;
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = {ADDR_W{1'b0}};
        mem_wdata_o = {DATA_W{1'b0}};
        mem_wmask_o = {MASK_W{1'b0}};
        if_rvalid_o = 1'b0;
        if_rdata_o  = {DATA_W{1'b0}};
        d_rvalid_o  = 1'b0;
        d_rdata_o   = {DATA_W{1'b0}};

        if (grant_d_s) begin
            d_gnt_o     = 1'b1;
            mem_en_o    = 1'b1;
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_wmask_o = d_wmask_i;
        end else if (grant_if_s) begin
            if_gnt_o    = 1'b1;
            mem_en_o    = 1'b1;
            mem_addr_o  = if_addr_i;
        end else begin
            mem_en_o    = 1'b0;
        end

        // Reset abandons the outstanding access, so no response escapes.
        if (rst_ni && (state_q == ST_RESP)) begin
            if (owner_data_q) begin
                d_rvalid_o = 1'b1;
                d_rdata_o  = we_q ? {DATA_W{1'b0}} : mem_rdata_i;
            end else begin
                if_rvalid_o = 1'b1;
                if_rdata_o  = mem_rdata_i;
            end
        end else begin
            if_rvalid_o = 1'b0;
            d_rvalid_o  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter. A timestamp-based model of the
// arbiter (one outstanding access that completes MEM_LAT cycles after its
// issue) and a sparse memory image predict every output on every cycle.
// Directed scenarios pin the model with literal values; a randomized phase
// follows.

module tb_mem_port_arbiter;

    localparam int MEM_LAT    = 2;
    localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req, d_we;
    logic [31:0] d_addr, d_wdata;
    logic [3:0]  d_wmask;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_wmask_i(d_wmask), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid),
        .d_rdata_o(d_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int          cyc = 0;
    bit          m_out = 1'b0;     // an access is outstanding
    int          m_due = 0;        // cycle its response is due
    bit          m_own_d = 1'b0;   // owner is the data requester
    bit          m_we = 1'b0;
    logic [31:0] m_rd = 32'd0;     // memory contents read at issue
    int          m_starve = 0;
    bit          resp_now, can_issue, force_f, e_dg, e_ig;
    bit          d_last_gnt = 1'b0, if_last_gnt = 1'b0;
    logic [31:0] mem_img [logic [31:0]];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Predict and check every output for the current cycle.
    task automatic eval();
        logic [31:0] e_addr, e_wd, e_ird, e_drd;
        logic [3:0]  e_wm;
        bit          e_irv, e_drv;
        resp_now  = m_out && (cyc == m_due);
        can_issue = rst_n && (!m_out || resp_now);
        force_f   = GUARD && (m_starve == STARVE_MAX) && if_req;
        e_dg      = can_issue && d_req && !force_f;
        e_ig      = can_issue && if_req && !e_dg;
        mem_rdata = resp_now ? m_rd : $urandom;
        #1;
        e_addr = e_dg ? d_addr : (e_ig ? if_addr : 32'd0);
        e_wd   = e_dg ? d_wdata : 32'd0;
        e_wm   = e_dg ? d_wmask : 4'd0;
        e_irv  = rst_n && resp_now && !m_own_d;
        e_drv  = rst_n && resp_now && m_own_d;
        e_ird  = e_irv ? m_rd : 32'd0;
        e_drd  = (e_drv && !m_we) ? m_rd : 32'd0;
        chk("if_gnt",    {31'd0, if_gnt},    {31'd0, e_ig});
        chk("d_gnt",     {31'd0, d_gnt},     {31'd0, e_dg});
        chk("mem_en",    {31'd0, mem_en},    {31'd0, e_dg | e_ig});
        chk("mem_we",    {31'd0, mem_we},    {31'd0, e_dg & d_we});
        chk("mem_addr",  mem_addr,  e_addr);
        chk("mem_wdata", mem_wdata, e_wd);
        chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, e_wm});
        chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, e_irv});
        chk("if_rdata",  if_rdata,  e_ird);
        chk("d_rvalid",  {31'd0, d_rvalid},  {31'd0, e_drv});
        chk("d_rdata",   d_rdata,   e_drd);
    endtask

    // Clock edge: advance the model, then move to the next drive point.
    task automatic advance();
        logic [31:0] a, w;
        @(posedge clk);
        d_last_gnt  = 1'b0;
        if_last_gnt = 1'b0;
        if (!rst_n) begin
            m_out    = 1'b0;
            m_starve = 0;
        end else begin
            if (resp_now) m_out = 1'b0;
            if (e_dg || e_ig) begin
                a       = e_dg ? d_addr : if_addr;
                m_out   = 1'b1;
                m_due   = cyc + MEM_LAT;
                m_own_d = e_dg;
                m_we    = e_dg && d_we;
                m_rd    = mem_read(a);
                if (m_we) begin
                    w = m_rd;
                    for (int b = 0; b < 4; b++)
                        if (d_wmask[b]) w[b*8 +: 8] = d_wdata[b*8 +: 8];
                    mem_img[a] = w;
                end
                if (e_ig) m_starve = 0;
                else if (if_req) m_starve++;
                d_last_gnt  = e_dg;
                if_last_gnt = e_ig;
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic step();
        eval();
        advance();
    endtask

    task automatic idle(input int n);
        if_req = 1'b0;
        d_req  = 1'b0;
        d_we   = 1'b0;
        repeat (n) step();
    endtask

    int fg, issues, budget;

    initial begin
        rst_n = 1'b0; if_req = 1'b0; if_addr = 32'd0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
        d_wmask = 4'd0; mem_rdata = 32'd0;
        mem_img[32'h100] = 32'h0050_0093;
        mem_img[32'h104] = 32'hCAFE_0104;
        @(negedge clk);

        // reset held with both requests high
        if_req = 1'b1; if_addr = 32'h40;
        d_req  = 1'b1; d_addr  = 32'h80;
        repeat (5) begin
            eval();
            chk("rst_no_mem_en", {31'd0, mem_en}, 32'd0);
            advance();
        end
        rst_n = 1'b1;
        eval();
        chk("rst_release_d_gnt", {31'd0, d_gnt}, 32'd1);
        advance();
        idle(4);

        // single fetch
        if_req = 1'b1; if_addr = 32'h100;
        eval();
        chk("fetch_gnt",  {31'd0, if_gnt}, 32'd1);
        chk("fetch_addr", mem_addr, 32'h100);
        advance();
        if_req = 1'b0;
        step();
        eval();
        chk("fetch_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("fetch_rdata",  if_rdata, 32'h0050_0093);
        advance();
        idle(2);

        // contention
        if_req = 1'b1; if_addr = 32'h104;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h8;
        eval();
        chk("cont_d_gnt", {31'd0, d_gnt}, 32'd1);
        advance();
        d_req = 1'b0;
        step();
        eval();
        chk("cont_d_rvalid", {31'd0, d_rvalid}, 32'd1);
        chk("cont_if_gnt",   {31'd0, if_gnt},   32'd1);
        advance();
        if_req = 1'b0;
        step();
        eval();
        chk("cont_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        advance();
        idle(2);

        // store
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200;
        d_wdata = 32'h1234_ABCD; d_wmask = 4'b0011;
        eval();
        chk("st_mem_we",    {31'd0, mem_we}, 32'd1);
        chk("st_mem_addr",  mem_addr, 32'h200);
        chk("st_mem_wdata", mem_wdata, 32'h1234_ABCD);
        chk("st_mem_wmask", {28'd0, mem_wmask}, 32'd3);
        advance();
        d_req = 1'b0; d_we = 1'b0;
        step();
        eval();
        chk("st_d_rvalid",  {31'd0, d_rvalid}, 32'd1);
        chk("st_d_rdata",   d_rdata, 32'd0);
        chk("st_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        advance();
        idle(2);

        // starvation: both requests held high for 20 issues
        fg = 0; issues = 0; budget = 0;
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_we = 1'b0;
        while (issues < 20 && budget < 200) begin
            d_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            eval();
            if (mem_en) issues++;
            if (if_gnt) fg++;
            advance();
            budget++;
        end
        chk("starve_issues", issues, 32'd20);
        chk("starve_fetch_grants", fg, GUARD ? 32'd4 : 32'd0);
        idle(3);

        // reset during WAIT
        if_req = 1'b1; if_addr = 32'h300;
        step();
        if_req = 1'b0; rst_n = 1'b0;
        step();
        rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h104;
        eval();
        chk("midrst_no_rvalid", {31'd0, if_rvalid}, 32'd0);
        chk("midrst_idle_gnt",  {31'd0, if_gnt},    32'd1);
        advance();
        if_req = 1'b0;
        step();
        eval();
        chk("midrst_rvalid", {31'd0, if_rvalid}, 32'd1);
        chk("midrst_rdata",  if_rdata, 32'hCAFE_0104);
        advance();
        idle(2);

        // randomized traffic honouring hold-until-grant
        for (int i = 0; i < 3000; i++) begin
            if (!if_req || if_last_gnt) begin
                if_req  = ($urandom_range(0, 99) < 50);
                if_addr = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            end
            if (!d_req || d_last_gnt) begin
                d_req   = ($urandom_range(0, 99) < 50);
                d_we    = ($urandom_range(0, 2) == 0);
                d_addr  = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                d_wdata = $urandom;
                d_wmask = 4'($urandom_range(0, 15));
            end
            rst_n = ($urandom_range(0, 199) != 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
